mem_stage_lsu: RTL and testbench

//  Memory-stage load/store unit: consumer of the EX/MEM pipeline register outputs (…M signals).

---
 rtl/mem_stage_lsu_pkg.sv | 22 ++
 rtl/mem_stage_lsu_if.sv | 25 ++
 rtl/mem_stage_lsu_lane_align.sv | 61 ++++++
 rtl/mem_stage_lsu.sv | 120 ++++++++++++
 tb/tb_mem_stage_lsu.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings for the memory-stage load/store unit: result-source select,
// load/store size codes and the LSU state type.
package mem_stage_lsu_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {IDLE, WAIT} lsu_state_t;

  // 011, 110 and 111 have no load/store meaning
  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/response channel between the LSU (master) and memory (slave).
interface mem_stage_lsu_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic [3:0]       req_be;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/mem_stage_lsu_lane_align.sv
// Combinational byte-lane logic: store data replication and byte enables, access
// fault detection, and load extraction with sign/zero extension.
module mem_stage_lsu_lane_align
  import mem_stage_lsu_pkg::*;
(
  input  logic        mem_op,
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        fault,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;
  logic        misaligned;

  always_comb begin
    wdata = st_data;
    be    = 4'b1111;
    case (st_funct3[1:0])
      2'b00: begin
        wdata = {4{st_data[7:0]}};
        be    = 4'b0001 << st_off;
      end
      2'b01: begin
        wdata = {2{st_data[15:0]}};
        be    = 4'b0011 << st_off;
      end
      default: ;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    case (st_funct3[1:0])
      2'b01:   misaligned = st_off[0];
      2'b10:   misaligned = (st_off != 2'b00);
      default: misaligned = 1'b0;
    endcase
    fault = mem_op & (f3_illegal(st_funct3) | misaligned);
  end

  assign shifted = rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_data = rdata;
    case (ld_funct3)
      F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ld_data = {24'h0, shifted[7:0]};
      F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ld_data = {16'h0, shifted[15:0]};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: issues valid/ready memory requests for loads and stores, stalls
// the front of the pipeline while an access is outstanding, and holds the MEM/WB register.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteM,
  input  logic [1:0]       ResultSrcM,
  input  logic             MemWriteM,
  input  logic [2:0]       Funct3M,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [WIDTH-1:0] WriteDataM,
  input  logic [4:0]       RdM,
  input  logic [WIDTH-1:0] PCPlus4M,
  output logic             StallM,
  mem_stage_lsu_if.master  mem,
  output logic             RegWriteW,
  output logic [1:0]       ResultSrcW,
  output logic [WIDTH-1:0] ALUResultW,
  output logic [WIDTH-1:0] ReadDataW,
  output logic [4:0]       RdW,
  output logic [WIDTH-1:0] PCPlus4W,
  output logic             MemFaultW
);

  lsu_state_t  state_q, state_d;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        mem_op, fault, req_valid, complete, load_done, load_accept;
  logic [31:0] ld_data;

  assign mem_op = MemWriteM | (ResultSrcM == RES_MEM);

  mem_stage_lsu_lane_align u_lane_align (
    .mem_op    (mem_op),
    .st_funct3 (Funct3M),
    .st_off    (ALUResultM[1:0]),
    .st_data   (WriteDataM),
    .wdata     (mem.req_wdata),
    .be        (mem.req_be),
    .fault     (fault),
    .ld_funct3 (f3_q),
    .ld_off    (off_q),
    .rdata     (mem.rsp_rdata),
    .ld_data   (ld_data)
  );

  assign mem.req_valid = req_valid;
  assign mem.req_we    = MemWriteM;
  assign mem.req_addr  = {ALUResultM[WIDTH-1:2], 2'b00};
  assign StallM        = ~complete;

  always_comb begin
    state_d     = state_q;
    req_valid   = 1'b0;
    complete    = ~mem_op | fault;
    load_done   = 1'b0;
    load_accept = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_valid = mem_op & ~fault;
        if (req_valid && mem.req_ready) begin
          if (MemWriteM) begin
            complete = 1'b1;
          end else begin
            load_accept = 1'b1;
            state_d     = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem.rsp_valid) begin
          complete  = 1'b1;
          load_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      off_q   <= 2'b00;
      f3_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      if (load_accept) begin
        off_q <= ALUResultM[1:0];
        f3_q  <= Funct3M;
      end
    end
  end

  // A stalled cycle retires nothing, so writeback sees a bubble
  always_ff @(posedge clk) begin
    if (rst || !complete) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      RdW        <= 5'd0;
      PCPlus4W   <= '0;
      MemFaultW  <= 1'b0;
    end else begin
      RegWriteW  <= RegWriteM & ~fault;
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= load_done ? ld_data : '0;
      RdW        <= RdM;
      PCPlus4W   <= PCPlus4M;
      MemFaultW  <= fault;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios plus randomized
// back-to-back traffic checked against a byte-level behavioural model.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        StallM;
  logic        RegWriteW, MemFaultW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;

  int checks = 0;
  int errors = 0;

  mem_stage_lsu_if #(.WIDTH(32)) mem ();

  mem_stage_lsu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .RdM        (RdM),
    .PCPlus4M   (PCPlus4M),
    .StallM     (StallM),
    .mem        (mem),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .RdW        (RdW),
    .PCPlus4W   (PCPlus4W),
    .MemFaultW  (MemFaultW)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input logic rw, input logic [1:0] rs, input logic mw,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd, input logic [31:0] pc4);
    RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; Funct3M = f3;
    ALUResultM = a; WriteDataM = d; RdM = rd; PCPlus4M = pc4;
  endtask

  task automatic nop();
    set_m(1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0);
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic m_fault(input logic is_mem, input logic [2:0] f3, input logic [31:0] a);
    if (!is_mem) return 1'b0;
    if (f3 == 3'd3 || f3 >= 3'd6) return 1'b1;
    return (a % nbytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be = 4'b0000;
    int off = int'(a % 4);
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + nbytes(f3));
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    int n = nbytes(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input int off, input logic [31:0] rdata);
    longint v = 0;
    int n = nbytes(f3);
    for (int k = 0; k < n; k++) v = v + (longint'(rdata[8*(off+k) +: 8]) << (8*k));
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; nop();
    mem.req_ready = 1'b0; mem.rsp_valid = 1'b0; mem.rsp_rdata = 32'h0;
    tick(); tick();
    checks++; if ({RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W, MemFaultW} !== '0) begin
      errors++; $display("FAIL reset_w got rd=%0d alu=%h pc4=%h rw=%b flt=%b exp all zero",
                         RdW, ALUResultW, PCPlus4W, RegWriteW, MemFaultW); end
    checks++; if ({mem.req_valid, StallM} !== 2'b00) begin
      errors++; $display("FAIL reset_req got valid=%b stall=%b exp 0 0", mem.req_valid, StallM); end
    rst = 1'b0;
  endtask

  task automatic test_store_word();
    set_m(1'b0, 2'b00, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 32'h1004);
    mem.req_ready = 1'b1;
    #1;
    checks++; if ({mem.req_valid, mem.req_we, mem.req_be, mem.req_wdata, StallM} !== {2'b11, 4'b1111, 32'hDEADBEEF, 1'b0}) begin
      errors++; $display("FAIL sw_req got v=%b we=%b be=%b wd=%h st=%b exp 1 1 1111 deadbeef 0",
                         mem.req_valid, mem.req_we, mem.req_be, mem.req_wdata, StallM); end
    tick();
    checks++; if ({RegWriteW, MemFaultW, ALUResultW} !== {2'b00, 32'h100}) begin
      errors++; $display("FAIL sw_w got rw=%b flt=%b alu=%h exp 0 0 100", RegWriteW, MemFaultW, ALUResultW); end
    mem.req_ready = 1'b0;
  endtask

  task automatic test_store_byte();
    set_m(1'b0, 2'b00, 1'b1, 3'b000, 32'h103, 32'h000000AB, 5'd0, 32'h1008);
    mem.req_ready = 1'b1;
    #1;
    checks++; if ({mem.req_addr, mem.req_be, mem.req_wdata, StallM} !== {32'h100, 4'b1000, 32'hABABABAB, 1'b0}) begin
      errors++; $display("FAIL sb_req got a=%h be=%b wd=%h st=%b exp 100 1000 abababab 0",
                         mem.req_addr, mem.req_be, mem.req_wdata, StallM); end
    tick();
    mem.req_ready = 1'b0;
  endtask

  task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] exp);
    set_m(1'b1, 2'b01, 1'b0, f3, 32'h102, 32'h0, 5'd5, 32'h2004);
    mem.req_ready = 1'b1;
    #1;
    checks++; if ({mem.req_valid, mem.req_we, StallM} !== 3'b101) begin
      errors++; $display("FAIL lb_accept got v=%b we=%b st=%b exp 1 0 1", mem.req_valid, mem.req_we, StallM); end
    tick();
    mem.req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if ({mem.req_valid, StallM, RegWriteW, RdW} !== {3'b010, 5'd0}) begin
        errors++; $display("FAIL lb_wait%0d got v=%b st=%b rw=%b rd=%0d exp 0 1 0 0",
                           i, mem.req_valid, StallM, RegWriteW, RdW); end
      tick();
    end
    mem.rsp_valid = 1'b1; mem.rsp_rdata = 32'h80FF7F01;
    #1;
    checks++; if (StallM !== 1'b0) begin
      errors++; $display("FAIL lb_rsp_stall got %b exp 0", StallM); end
    tick();
    mem.rsp_valid = 1'b0; nop();
    checks++; if ({RegWriteW, RdW, ResultSrcW, ReadDataW} !== {1'b1, 5'd5, 2'b01, exp}) begin
      errors++; $display("FAIL lb_w f3=%0d got rw=%b rd=%0d rs=%b data=%h exp 1 5 01 %h",
                         f3, RegWriteW, RdW, ResultSrcW, ReadDataW, exp); end
  endtask

  task automatic test_misaligned();
    set_m(1'b1, 2'b01, 1'b0, 3'b001, 32'h101, 32'h0, 5'd7, 32'h3004);
    mem.req_ready = 1'b1;
    #1;
    checks++; if ({mem.req_valid, StallM} !== 2'b00) begin
      errors++; $display("FAIL lh_mis_req got v=%b st=%b exp 0 0", mem.req_valid, StallM); end
    tick();
    checks++; if ({MemFaultW, RegWriteW, RdW} !== {2'b10, 5'd7}) begin
      errors++; $display("FAIL lh_mis_w got flt=%b rw=%b rd=%0d exp 1 0 7", MemFaultW, RegWriteW, RdW); end
    set_m(1'b0, 2'b00, 1'b1, 3'b011, 32'h100, 32'h55, 5'd0, 32'h3008);
    #1;
    checks++; if ({mem.req_valid, StallM} !== 2'b00) begin
      errors++; $display("FAIL bad_f3_req got v=%b st=%b exp 0 0", mem.req_valid, StallM); end
    tick();
    checks++; if (MemFaultW !== 1'b1) begin
      errors++; $display("FAIL bad_f3_w got flt=%b exp 1", MemFaultW); end
    mem.req_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    set_m(1'b0, 2'b00, 1'b1, 3'b010, 32'h200, 32'h12345678, 5'd3, 32'h4004);
    mem.req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if ({mem.req_valid, mem.req_addr, mem.req_wdata, StallM} !== {1'b1, 32'h200, 32'h12345678, 1'b1}) begin
        errors++; $display("FAIL bp_hold%0d got v=%b a=%h wd=%h st=%b exp 1 200 12345678 1",
                           i, mem.req_valid, mem.req_addr, mem.req_wdata, StallM); end
      tick();
      checks++; if ({RegWriteW, RdW, MemFaultW, ALUResultW, PCPlus4W} !== '0) begin
        errors++; $display("FAIL bp_bubble%0d got rd=%0d alu=%h pc4=%h exp zero", i, RdW, ALUResultW, PCPlus4W); end
    end
    mem.req_ready = 1'b1;
    #1;
    checks++; if (StallM !== 1'b0) begin
      errors++; $display("FAIL bp_accept_stall got %b exp 0", StallM); end
    tick();
    checks++; if ({ALUResultW, PCPlus4W, RdW} !== {32'h200, 32'h4004, 5'd3}) begin
      errors++; $display("FAIL bp_w got alu=%h pc4=%h rd=%0d exp 200 4004 3", ALUResultW, PCPlus4W, RdW); end
    mem.req_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    set_m(1'b1, 2'b01, 1'b0, 3'b010, 32'h300, 32'h0, 5'd9, 32'h5004);
    mem.req_ready = 1'b1;
    tick();
    mem.req_ready = 1'b0; rst = 1'b1; nop();
    tick();
    rst = 1'b0;
    checks++; if ({RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W, MemFaultW} !== '0) begin
      errors++; $display("FAIL rstw_w got rd=%0d alu=%h rw=%b exp all zero", RdW, ALUResultW, RegWriteW); end
    // Late response arrives while a fresh, not-yet-accepted load waits in IDLE
    mem.rsp_valid = 1'b1; mem.rsp_rdata = 32'hFFFFFFFF;
    set_m(1'b1, 2'b01, 1'b0, 3'b000, 32'h300, 32'h0, 5'd9, 32'h5008);
    #1;
    checks++; if ({mem.req_valid, StallM} !== 2'b11) begin
      errors++; $display("FAIL rstw_late got v=%b st=%b exp 1 1", mem.req_valid, StallM); end
    tick();
    checks++; if ({RegWriteW, RdW, ReadDataW} !== '0) begin
      errors++; $display("FAIL rstw_ignored got rw=%b rd=%0d data=%h exp 0 0 0", RegWriteW, RdW, ReadDataW); end
    mem.rsp_valid = 1'b0; rst = 1'b1; nop();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- randomized back-to-back traffic ----------------
  task automatic test_random(input int nops);
    for (int op = 0; op < nops; op++) begin
      int kind = $urandom_range(0, 3);
      logic [2:0] f3 = 3'($urandom_range(0, 7));
      logic [31:0] a = $urandom;
      logic [31:0] d = $urandom;
      logic [31:0] pc4 = $urandom;
      logic [31:0] rdata = $urandom;
      logic [4:0] rd = 5'($urandom_range(0, 31));
      logic rw = 1'($urandom_range(0, 1));
      logic [1:0] rs;
      logic is_mem, flt;
      logic [31:0] exp_rd = 32'h0;
      if ($urandom_range(0, 3) != 0) a = a - (a % nbytes(f3));
      rs = (kind == 1) ? 2'b01 : (kind == 3) ? 2'b10 : 2'b00;
      is_mem = (kind == 1) || (kind == 2);
      flt = m_fault(is_mem, f3, a);
      set_m(rw, rs, kind == 2, f3, a, d, rd, pc4);
      if (!is_mem || flt) begin
        mem.req_ready = 1'($urandom_range(0, 1));
        mem.rsp_valid = 1'($urandom_range(0, 1));
        #1;
        checks++; if ({mem.req_valid, StallM} !== 2'b00) begin
          errors++; $display("FAIL rnd_pass op=%0d got v=%b st=%b exp 0 0", op, mem.req_valid, StallM); end
        tick();
      end else begin
        int delay = $urandom_range(0, 2);
        for (int i = 0; i <= delay; i++) begin
          mem.req_ready = (i == delay);
          mem.rsp_valid = (i == delay) ? 1'b0 : 1'($urandom_range(0, 1));
          #1;
          checks++; if ({mem.req_valid, mem.req_we, mem.req_addr} !== {1'b1, kind == 2, a & 32'hFFFFFFFC}) begin
            errors++; $display("FAIL rnd_req op=%0d got v=%b we=%b a=%h exp 1 %0d %h",
                               op, mem.req_valid, mem.req_we, mem.req_addr, kind == 2, a & 32'hFFFFFFFC); end
          if (kind == 2) begin
            checks++; if ({mem.req_be, mem.req_wdata} !== {m_be(f3, a), m_wdata(f3, d)}) begin
              errors++; $display("FAIL rnd_lanes op=%0d f3=%0d a=%h got be=%b wd=%h exp %b %h",
                                 op, f3, a, mem.req_be, mem.req_wdata, m_be(f3, a), m_wdata(f3, d)); end
          end
          checks++; if (StallM !== ((i < delay) || kind == 1)) begin
            errors++; $display("FAIL rnd_stall op=%0d cyc=%0d got %b", op, i, StallM); end
          tick();
          if (i < delay || kind == 1) begin
            checks++; if ({RegWriteW, RdW, MemFaultW, ALUResultW} !== '0) begin
              errors++; $display("FAIL rnd_bubble op=%0d got rw=%b rd=%0d alu=%h exp zero",
                                 op, RegWriteW, RdW, ALUResultW); end
          end
        end
        if (kind == 1) begin
          int lat = $urandom_range(0, 2);
          for (int i = 0; i < lat; i++) begin
            mem.req_ready = 1'($urandom_range(0, 1)); mem.rsp_valid = 1'b0;
            #1;
            checks++; if ({mem.req_valid, StallM} !== 2'b01) begin
              errors++; $display("FAIL rnd_wait op=%0d got v=%b st=%b exp 0 1", op, mem.req_valid, StallM); end
            tick();
          end
          mem.req_ready = 1'b0; mem.rsp_valid = 1'b1; mem.rsp_rdata = rdata;
          #1;
          checks++; if ({mem.req_valid, StallM} !== 2'b00) begin
            errors++; $display("FAIL rnd_rsp op=%0d got v=%b st=%b exp 0 0", op, mem.req_valid, StallM); end
          tick();
          exp_rd = m_load(f3, int'(a % 4), rdata);
          checks++; if (ReadDataW !== exp_rd) begin
            errors++; $display("FAIL rnd_load op=%0d f3=%0d off=%0d raw=%h got %h exp %h",
                               op, f3, a % 4, rdata, ReadDataW, exp_rd); end
        end
        mem.req_ready = 1'b0; mem.rsp_valid = 1'b0;
      end
      checks++; if ({RegWriteW, ResultSrcW, ALUResultW, RdW, PCPlus4W, MemFaultW} !==
                    {rw & ~flt, rs, a, rd, pc4, flt}) begin
        errors++; $display("FAIL rnd_w op=%0d kind=%0d got rw=%b rs=%b alu=%h rd=%0d pc4=%h flt=%b exp %b %b %h %0d %h %b",
                           op, kind, RegWriteW, ResultSrcW, ALUResultW, RdW, PCPlus4W, MemFaultW,
                           rw & ~flt, rs, a, rd, pc4, flt); end
    end
    nop();
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte();
    test_load_byte(3'b000, 32'hFFFFFFFF);
    test_load_byte(3'b100, 32'h000000FF);
    test_misaligned();
    test_backpressure();
    test_reset_mid_wait();
    test_random(400);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
